// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity modes, data-bit encodings.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Index of the last data bit sent for a given data-bits code (5 bits -> 4).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
    return 3'd4 + {1'b0, code};
  endfunction

  // Mask selecting the data bits that belong to the frame.
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    logic [7:0] m;
    case (code)
      DBITS_5: m = 8'h1F;
      DBITS_6: m = 8'h3F;
      DBITS_7: m = 8'h7F;
      DBITS_8: m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the mode inserts a parity bit.
  function automatic logic parity_on(input logic [1:0] mode);
    logic on;
    case (mode)
      PAR_NONE:     on = 1'b0;
      PAR_EVEN:     on = 1'b1;
      PAR_ODD:      on = 1'b1;
      PAR_NONE_ALT: on = 1'b0;
      default:      on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with register storage, full/empty flags and a word-count level.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped silently.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // Head word comes straight out of the storage registers.
  assign pop_dat = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ex.sv
// UART transmitter with TX FIFO, 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
// Latency: start bit appears on Out_tx the edge after a word lands in an empty FIFO while idle.
// Backpressure: In_data_rdy low while the FIFO is full; In_data_vld is ignored then.
module uart_tx_ex
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [7:0]                    In_data,
  input  logic                          In_data_vld,
  output logic                          In_data_rdy,
  input  logic [DIV_W-1:0]              Cfg_div,
  input  logic [1:0]                    Cfg_data_bits,
  input  logic [1:0]                    Cfg_parity,
  input  logic                          Cfg_stop2,
  output logic                          Out_tx,
  output logic                          Out_busy,
  output logic                          Out_send_done,
  output logic [$clog2(FIFO_DEPTH):0]   Out_fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       data_q;
  logic [1:0]       dbits_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop2_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dat;
  logic [LW-1:0]    fifo_level;
  logic             pop;
  logic             bit_end;
  logic             frame_end;
  logic [DIV_W-1:0] period_m1;
  logic             par_next;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push     (In_data_vld),
    .push_dat (In_data),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign In_data_rdy    = ~fifo_full;
  assign Out_fifo_level = fifo_level;
  assign Out_busy       = (state != IDLE) || !fifo_empty;

  // A bit period ends on the edge where the down-counter sits at zero.
  assign bit_end   = (baud_cnt == '0);
  assign frame_end = (state == STOP) && bit_end && (stop_idx || !stop2_q);
  // A new frame starts from IDLE or back-to-back straight out of the last stop bit.
  assign pop       = !Rst && !fifo_empty && ((state == IDLE) || frame_end);
  // Bit period is never shorter than two clocks; Cfg_div is read live at each boundary.
  assign period_m1 = (Cfg_div < DIV_W'(2)) ? DIV_W'(1) : (Cfg_div - DIV_W'(1));
  // Parity over only the bits that will be sent, inverted for odd mode.
  assign par_next  = (^(fifo_dat & data_mask(Cfg_data_bits))) ^ (Cfg_parity == PAR_ODD);

  // Frame sequencer: baud/bit counting, line driver and done pulse, all registered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      data_q        <= '0;
      dbits_q       <= DBITS_8;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      Out_tx        <= 1'b1;
      Out_send_done <= 1'b0;
    end else begin
      Out_send_done <= 1'b0;
      if (state != IDLE && !bit_end) begin
        baud_cnt <= baud_cnt - DIV_W'(1);
      end

      case (state)
        IDLE: begin
          Out_tx <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            Out_tx   <= data_q[0];
            bit_idx  <= '0;
            baud_cnt <= period_m1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= period_m1;
            if (bit_idx == last_bit_idx(dbits_q)) begin
              if (par_en_q) begin
                state  <= PARITY;
                Out_tx <= par_bit_q;
              end else begin
                state    <= STOP;
                Out_tx   <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              Out_tx  <= data_q[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            Out_tx   <= 1'b1;
            stop_idx <= 1'b0;
            baud_cnt <= period_m1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (frame_end) begin
              Out_send_done <= 1'b1;
              state         <= IDLE;
              Out_tx        <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
              baud_cnt <= period_m1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          Out_tx <= 1'b1;
        end
      endcase

      // Starting a frame overrides the per-state updates above; config is frozen here.
      if (pop) begin
        state     <= START;
        Out_tx    <= 1'b0;
        baud_cnt  <= period_m1;
        data_q    <= fifo_dat;
        dbits_q   <= Cfg_data_bits;
        par_en_q  <= parity_on(Cfg_parity);
        par_bit_q <= par_next;
        stop2_q   <= Cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ex.sv
// Scoreboard bench for uart_tx_ex: stimulus queues expected frames, a monitor decodes the line.
// Latency: frames are checked cycle by cycle from the start bit to the done pulse.
// Backpressure: the burst test holds In_data_vld high and follows In_data_rdy.
module tb_uart_tx_ex;

  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          Clk;
  logic          Rst;
  logic [7:0]    In_data;
  logic          In_data_vld;
  logic          In_data_rdy;
  logic [DW-1:0] Cfg_div;
  logic [1:0]    Cfg_data_bits;
  logic [1:0]    Cfg_parity;
  logic          Cfg_stop2;
  logic          Out_tx;
  logic          Out_busy;
  logic          Out_send_done;
  logic [4:0]    Out_fifo_level;

  uart_tx_ex #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .In_data        (In_data),
    .In_data_vld    (In_data_vld),
    .In_data_rdy    (In_data_rdy),
    .Cfg_div        (Cfg_div),
    .Cfg_data_bits  (Cfg_data_bits),
    .Cfg_parity     (Cfg_parity),
    .Cfg_stop2      (Cfg_stop2),
    .Out_tx         (Out_tx),
    .Out_busy       (Out_busy),
    .Out_send_done  (Out_send_done),
    .Out_fifo_level (Out_fifo_level)
  );

  typedef struct packed {
    logic [7:0]       id;
    logic [4:0]       nb;
    logic [15:0]      bits;
    logic [15:0][7:0] per;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   done_cnt   = 0;
  int   frames_exp = 0;
  int   cyc        = 0;
  logic mon_off    = 1'b0;
  logic chk_gap    = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Every observed done cycle counts; a stretched or spurious pulse inflates the total.
  always @(negedge Clk) if (Out_send_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // Expected frame from a hand-written bit string; leftmost literal bit is sent first.
  function automatic exp_t seq_exp(input int id, input int nb, input logic [15:0] seq, input int div);
    exp_t e;
    e = '0;
    e.id = 8'(id);
    e.nb = 5'(nb);
    for (int i = 0; i < nb; i++) begin
      e.bits[i] = seq[nb-1-i];
      e.per[i]  = 8'(div);
    end
    return e;
  endfunction

  // Reference frame builder used for the bulk traffic.
  function automatic exp_t make_exp(input int id, input logic [7:0] d, input logic [1:0] db,
                                    input logic [1:0] par, input logic st2, input int div);
    exp_t e;
    int   n;
    int   k;
    int   p;
    logic pb;
    e  = '0;
    n  = 5 + int'(db);
    p  = (div < 2) ? 2 : div;
    k  = 0;
    pb = 1'b0;
    e.bits[k] = 1'b0; k++;
    for (int i = 0; i < n; i++) begin
      e.bits[k] = d[i];
      pb = pb ^ d[i];
      k++;
    end
    if (par == 2'b01 || par == 2'b10) begin
      e.bits[k] = pb ^ (par == 2'b10);
      k++;
    end
    e.bits[k] = 1'b1; k++;
    if (st2) begin
      e.bits[k] = 1'b1;
      k++;
    end
    for (int i = 0; i < k; i++) e.per[i] = 8'(p);
    e.nb = 5'(k);
    e.id = 8'(id);
    return e;
  endfunction

  task automatic expect_frame(input exp_t e);
    exp_q.push_back(e);
    frames_exp++;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge Clk);
    In_data     = d;
    In_data_vld = 1'b1;
    while (In_data_rdy !== 1'b1 && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 2000) fail_now("push_rdy_wait");
    @(negedge Clk);
    In_data_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((Out_busy !== 1'b0 || exp_q.size() != 0) && t < 5000) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 5000) fail_now(name);
    repeat (3) @(negedge Clk);
  endtask

  task automatic wait_start(input string name);
    int t;
    t = 0;
    @(negedge Clk);
    while (Out_tx !== 1'b0 && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 2000) fail_now(name);
  endtask

  // Entered on the first sampled cycle of a start bit; returns on the done-pulse cycle.
  task automatic check_frame(input exp_t e);
    logic bad;
    logic bad_val;
    for (int i = 0; i < int'(e.nb); i++) begin
      bad     = 1'b0;
      bad_val = e.bits[i];
      for (int c = 0; c < int'(e.per[i]); c++) begin
        if (!(i == 0 && c == 0)) @(negedge Clk);
        if (!bad && Out_tx !== e.bits[i]) begin
          bad     = 1'b1;
          bad_val = Out_tx;
        end
      end
      check($sformatf("frame%0d_bit%0d_cycles", e.id, i), 32'(bad_val), 32'(e.bits[i]));
    end
    @(negedge Clk);
    check($sformatf("frame%0d_done_pulse", e.id), 32'(Out_send_done), 32'd1);
  endtask

  // Monitor: waits for a start bit, pops the next expectation and checks the whole frame.
  initial begin : monitor
    exp_t e;
    logic carry;
    int   t;
    carry = 1'b0;
    forever begin
      if (!carry) begin
        @(negedge Clk);
        while (Out_tx !== 1'b0 || mon_off) @(negedge Clk);
      end
      carry = 1'b0;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got start bit at cycle %0d, want idle line", cyc);
        t = 0;
        while (Out_tx === 1'b0 && t < 200) begin
          @(negedge Clk);
          t++;
        end
      end else begin
        e = exp_q.pop_front();
        check_frame(e);
        if (chk_gap && exp_q.size() > 0) check("no_idle_gap", 32'(Out_tx), 32'd0);
        if (Out_tx === 1'b0) carry = 1'b1;
      end
    end
  end

  // Stimulus
  initial begin : stim
    exp_t e;
    int   idx;
    int   t;
    int   full_level;
    int   rdy_bad;
    int   start_cyc;
    int   line_bad;
    int   done_seen;
    logic seen_full;
    logic [7:0] bval;

    Rst           = 1'b1;
    In_data       = 8'h00;
    In_data_vld   = 1'b0;
    Cfg_div       = 16'd4;
    Cfg_data_bits = 2'b11;
    Cfg_parity    = 2'b00;
    Cfg_stop2     = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_tx",    32'(Out_tx),         32'd1);
    check("reset_done",  32'(Out_send_done),  32'd0);
    check("reset_busy",  32'(Out_busy),       32'd0);
    check("reset_level", 32'(Out_fifo_level), 32'd0);
    check("reset_rdy",   32'(In_data_rdy),    32'd1);
    Rst = 1'b0;
    @(negedge Clk);

    // 8N1, divisor 4, 0xA5
    expect_frame(seq_exp(1, 10, 16'b0101001011, 4));
    push_byte(8'hA5);
    wait_idle("idle_t1");

    // 5 data bits, even parity, two stop bits, 0xFF
    Cfg_data_bits = 2'b00;
    Cfg_parity    = 2'b01;
    Cfg_stop2     = 1'b1;
    expect_frame(seq_exp(2, 9, 16'b011111111, 4));
    push_byte(8'hFF);
    wait_idle("idle_t2");

    // 7 data bits, odd parity, one stop bit, 0x80 (bit 7 dropped)
    Cfg_data_bits = 2'b10;
    Cfg_parity    = 2'b10;
    Cfg_stop2     = 1'b0;
    expect_frame(seq_exp(3, 10, 16'b0000000011, 4));
    push_byte(8'h80);
    wait_idle("idle_t3");

    // 8E1, 0x3C: divisor 4 -> 8 during bit 2, parity flipped to odd mid-frame
    Cfg_data_bits = 2'b11;
    Cfg_parity    = 2'b01;
    e = seq_exp(4, 11, 16'b00011110001, 4);
    for (int i = 3; i < 11; i++) e.per[i] = 8'd8;
    expect_frame(e);
    push_byte(8'h3C);
    wait_start("start_t4");
    repeat (9) @(negedge Clk);
    Cfg_div    = 16'd8;
    Cfg_parity = 2'b10;
    wait_idle("idle_t4");
    Cfg_div    = 16'd4;
    Cfg_parity = 2'b00;

    // Burst of 20 writes with valid held high, divisor 2, 8N1
    Cfg_div    = 16'd2;
    chk_gap    = 1'b1;
    idx        = 0;
    t          = 0;
    rdy_bad    = 0;
    seen_full  = 1'b0;
    full_level = -1;
    @(negedge Clk);
    In_data_vld = 1'b1;
    while (idx < 20 && t < 3000) begin
      bval    = 8'(16 + idx * 37);
      In_data = bval;
      if ((Out_fifo_level == 5'd16) == (In_data_rdy === 1'b1)) rdy_bad++;
      if (In_data_rdy === 1'b1) begin
        expect_frame(make_exp(10 + idx, bval, 2'b11, 2'b00, 1'b0, 2));
        idx++;
      end else if (!seen_full) begin
        seen_full  = 1'b1;
        full_level = int'(Out_fifo_level);
      end
      @(negedge Clk);
      t++;
    end
    In_data_vld = 1'b0;
    check("burst_writes_accepted", 32'(idx), 32'd20);
    check("burst_rdy_drop_level", 32'(full_level), 32'd16);
    check("burst_rdy_vs_level", 32'(rdy_bad), 32'd0);
    wait_idle("idle_burst");
    chk_gap = 1'b0;

    // Reset in the middle of data bit 3 with a second word still queued
    Cfg_div = 16'd4;
    mon_off = 1'b1;
    push_byte(8'h00);
    wait_start("start_rst");
    start_cyc = cyc;
    push_byte(8'h11);
    check("rst_pre_level", 32'(Out_fifo_level), 32'd1);
    t = 0;
    while (cyc < start_cyc + 18 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 100) fail_now("rst_align");
    check("rst_pre_tx_bit3", 32'(Out_tx), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_mid_tx",    32'(Out_tx),         32'd1);
    check("rst_mid_level", 32'(Out_fifo_level), 32'd0);
    check("rst_mid_busy",  32'(Out_busy),       32'd0);
    check("rst_mid_rdy",   32'(In_data_rdy),    32'd1);
    check("rst_mid_done",  32'(Out_send_done),  32'd0);
    Rst = 1'b0;
    line_bad  = 0;
    done_seen = 0;
    repeat (60) begin
      @(negedge Clk);
      if (Out_tx !== 1'b1) line_bad++;
      if (Out_send_done !== 1'b0) done_seen++;
    end
    check("rst_line_stays_idle", 32'(line_bad), 32'd0);
    check("rst_no_done_pulse", 32'(done_seen), 32'd0);
    mon_off = 1'b0;

    // Normal frame after the abort: 8 data bits, odd parity, two stop bits
    Cfg_parity = 2'b10;
    Cfg_stop2  = 1'b1;
    expect_frame(make_exp(40, 8'hC3, 2'b11, 2'b10, 1'b1, 4));
    push_byte(8'hC3);
    wait_idle("idle_post_rst");

    repeat (5) @(negedge Clk);
    check("done_pulse_count", 32'(done_cnt), 32'(frames_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ex.md
UART_TX_EX -- requirements
Module: uart_tx_ex

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-003 SHALL have port Clk, input, 1, clock; all logic on posedge.
REQ-004 SHALL have port Rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port In_data, input, 8, byte to transmit.
REQ-006 SHALL have port In_data_vld, input, 1, write request.
REQ-007 SHALL have port In_data_rdy, output, 1, FIFO can accept a word.
REQ-008 SHALL have port Cfg_div, input, DIV_W, clocks per bit.
REQ-009 SHALL have port Cfg_data_bits, input, 2, data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-010 SHALL have port Cfg_parity, input, 2, parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-011 SHALL have port Cfg_stop2, input, 1, stop bits per frame: 0=1, 1=2.
REQ-012 SHALL have port Out_tx, output, 1, serial line, registered.
REQ-013 SHALL have port Out_busy, output, 1, high while a frame is being sent or the FIFO is non-empty.
REQ-014 SHALL have port Out_send_done, output, 1, one-cycle pulse at the end of each frame.
REQ-015 SHALL have port Out_fifo_level, output, $clog2(FIFO_DEPTH)+1, number of words in the FIFO.

Function
REQ-016 SHALL push In_data into the FIFO on a Clk edge where In_data_vld and In_data_rdy are both 1.
REQ-017 SHALL drive In_data_rdy = 1 exactly when the FIFO is not full, and SHALL ignore In_data_vld while it is 0 (no overwrite, no error).
REQ-018 SHALL leave Out_fifo_level unchanged when a push and a pop happen on the same edge.
REQ-019 SHALL implement a state machine with states IDLE, START, DATA, PARITY and STOP.
REQ-020 SHALL move IDLE to START when the FIFO is non-empty, popping one word and latching Cfg_data_bits, Cfg_parity and Cfg_stop2 on that edge.
REQ-021 SHALL hold the latched configuration for the whole frame; Cfg changes mid-frame SHALL take effect only at the next frame.
REQ-022 SHALL drive Out_tx low on the edge after the push when a word is written into an empty FIFO while the machine is in IDLE.
REQ-023 SHALL hold each bit period for max(Cfg_div, 2) clocks, with Cfg_div resampled at each bit boundary.
REQ-024 SHALL send, per bit period: START = 0; DATA = N bits, LSB first, with bits above N ignored; PARITY; STOP = 1 for one or two periods.
REQ-025 SHALL skip the PARITY state when parity is none.
REQ-026 SHALL compute the parity bit as the XOR of the N data bits for even parity, and its inverse for odd parity.
REQ-027 SHALL pulse Out_send_done for one cycle on the edge that ends the last stop period.
REQ-028 SHALL, on that same edge, go directly STOP to START with no idle gap if the FIFO is non-empty, otherwise return to IDLE.
REQ-029 SHALL hold Out_tx at 1 in IDLE.

Reset
REQ-030 SHALL, on Rst, set Out_tx=1, Out_send_done=0, Out_busy=0, Out_fifo_level=0 and In_data_rdy=1 from the next cycle.
REQ-031 SHALL, on Rst, set the state to IDLE, clear the counters and empty the FIFO.
REQ-032 SHALL, on Rst mid-frame, abort the frame with Out_tx=1 on the next edge and no Out_send_done pulse.

Structure
REQ-033 SHALL take from shared package uart_pkg: the state enum, the parity-mode constants and the data-bits encoding constants.
REQ-034 SHALL instantiate the FIFO as sub-module uart_sync_fifo (synchronous, registered output, full/empty/level flags).
REQ-035 SHALL keep the baud counter and the bit counter inside uart_tx_ex.

Verification
REQ-036 SHALL cover: Cfg_div=4, 8N1, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; one Out_send_done pulse 40 clocks after the start bit.
REQ-037 SHALL cover: Cfg_data_bits=00, even parity, 2 stop bits, push 0xFF -> 5 ones, parity=1, 2 stop bits; frame = 9 bit periods.
REQ-038 SHALL cover: odd parity, 7 data bits, push 0x80 -> data 0000000 (bit 7 ignored), parity=1.
REQ-039 SHALL cover: FIFO_DEPTH=16, 20 writes with In_data_vld held high -> In_data_rdy drops at level 16; 20 back-to-back frames sent with no idle gap.
REQ-040 SHALL cover: Rst asserted in the middle of data bit 3 -> Out_tx=1 next cycle, level 0, no done pulse; next push sends normally.
REQ-041 SHALL cover: Cfg_div changed from 4 to 8 mid-frame -> new period applies from the next bit boundary; Cfg_parity change mid-frame has no effect on the current frame.
